div_unit: RTL and testbench

- Multi-cycle radix-2 restoring integer divider for the EXU. It executes RV64 DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW.
- Returns the quotient and remainder together.
- Uses valid/ready handshakes on both the issue side and the result side.
- Each iteration is a trial subtraction with borrow detection, the subtract counterpart of the adder carry-lookahead path.

---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 159 +++++++++++++++
 tb/tb_div_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the EXU integer divider.
// Imported by div_unit and div_step.
package div_unit_pkg;

  localparam int XLEN = 64;
  localparam int W_LEN = 32;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration.
// Shift in a dividend bit, then trial-subtract the divisor.
module div_step #(
  parameter int W = 65
) (
  input  logic [W-1:0] rem_in,
  input  logic         in_bit,
  input  logic [W-2:0] dvsr,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic         unused_hi;

  assign shifted = {rem_in, in_bit};
  assign diff    = {1'b0, shifted} - {3'b000, dvsr};

  // A set top bit is the borrow: the trial subtraction failed.
  assign q_bit   = ~diff[W+1];
  assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

  assign unused_hi = diff[W] ^ shifted[W];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV64 DIV/REM and W-forms.
// Quotient and remainder are returned together over valid/ready.
module div_unit #(
  parameter int XLEN = div_unit_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            is_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  import div_unit_pkg::*;

  localparam int CW = $clog2(XLEN) + 1;
  localparam int WL = W_LEN;
  localparam int HZ = XLEN - WL;

  function automatic logic [XLEN-1:0] sext_w(
    input logic [XLEN-1:0] v
  );
    return {{HZ{v[WL-1]}}, v[WL-1:0]};
  endfunction

  state_t state, state_nx;

  logic [CW-1:0]   cnt, last;
  logic [XLEN:0]   prem, prem_nx;
  logic [XLEN-1:0] dq, dvsr, quo_q, rem_q;
  logic            word_q, neg_q, neg_r, q_bit;

  logic            accept, a_neg, b_neg;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] a_op, b_op, a_ng, b_ng;
  logic [XLEN-1:0] a_mag, b_mag, a_res;
  logic [XLEN-1:0] min_op, ones_op;
  logic [XLEN-1:0] q_raw, r_raw, q_sn, r_sn;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  assign accept = in_valid & in_ready & ~flush;

  // Operands zero-extended to the op width.
  assign a_op = is_word ? {{HZ{1'b0}}, dividend[WL-1:0]}
                        : dividend;
  assign b_op = is_word ? {{HZ{1'b0}}, divisor[WL-1:0]}
                        : divisor;

  assign a_neg = is_signed &
    (is_word ? dividend[WL-1] : dividend[XLEN-1]);
  assign b_neg = is_signed &
    (is_word ? divisor[WL-1] : divisor[XLEN-1]);

  assign a_ng = -a_op;
  assign b_ng = -b_op;

  assign a_mag = !a_neg  ? a_op :
                 is_word ? {{HZ{1'b0}}, a_ng[WL-1:0]} : a_ng;
  assign b_mag = !b_neg  ? b_op :
                 is_word ? {{HZ{1'b0}}, b_ng[WL-1:0]} : b_ng;

  assign min_op = is_word
    ? {{HZ{1'b0}}, 1'b1, {(WL-1){1'b0}}}
    : {1'b1, {(XLEN-1){1'b0}}};
  assign ones_op = is_word ? {{HZ{1'b0}}, {WL{1'b1}}} : '1;

  assign b_zero  = (b_op == '0);
  assign ovf     = is_signed & (a_op == min_op)
                 & (b_op == ones_op);
  assign special = b_zero | ovf;
  assign a_res   = is_word ? sext_w(dividend) : dividend;

  div_step #(.W(XLEN + 1)) u_step (
    .rem_in  (prem),
    .in_bit  (dq[XLEN-1]),
    .dvsr    (dvsr),
    .rem_out (prem_nx),
    .q_bit   (q_bit)
  );

  assign last = word_q ? CW'(WL - 1) : CW'(XLEN - 1);

  assign q_raw = word_q ? {{HZ{1'b0}}, dq[WL-1:0]} : dq;
  assign r_raw = word_q ? {{HZ{1'b0}}, prem[WL-1:0]}
                        : prem[XLEN-1:0];
  assign q_sn  = neg_q ? -q_raw : q_raw;
  assign r_sn  = neg_r ? -r_raw : r_raw;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = special ? DONE : CALC;
      CALC: if (cnt == last) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt    <= '0;
      prem   <= '0;
      dq     <= '0;
      dvsr   <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      word_q <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          cnt    <= '0;
          prem   <= '0;
          dvsr   <= b_mag;
          word_q <= is_word;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          // Left-align W-form dividends so the low half ends as quotient.
          dq <= is_word ? {a_mag[WL-1:0], {HZ{1'b0}}} : a_mag;
          if (b_zero) begin
            quo_q <= DIV_ZERO_Q;
            rem_q <= a_res;
          end else if (ovf) begin
            quo_q <= a_res;
            rem_q <= '0;
          end
        end
        CALC: begin
          dq   <= {dq[XLEN-2:0], q_bit};
          prem <= prem_nx;
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          quo_q <= word_q ? sext_w(q_sn) : q_sn;
          rem_q <= word_q ? sext_w(r_sn) : r_sn;
        end
        DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// Random and directed ops compared to an arithmetic model.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        is_signed;
  logic        is_word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;

  int total = 0;
  int bad = 0;

  div_unit #(.XLEN(64)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .is_word   (is_word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // RISC-V division semantics with plain arithmetic.
  function automatic void model(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  bit          s,
    input  bit          w,
    output logic [63:0] q,
    output logic [63:0] r,
    output int          lat
  );
    logic [31:0] a32, b32, q32, r32;
    bit sp;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      sp = 1;
      if (b32 == 0) begin
        q32 = '1;
        r32 = a32;
      end else if (s && a32 == 32'h8000_0000 &&
                   b32 == 32'hFFFF_FFFF) begin
        q32 = a32;
        r32 = 0;
      end else if (s) begin
        sp = 0;
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        sp = 0;
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
      lat = sp ? 1 : 34;
    end else begin
      sp = 1;
      if (b == 0) begin
        q = '1;
        r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 &&
                   b == '1) begin
        q = a;
        r = 0;
      end else if (s) begin
        sp = 0;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        sp = 0;
        q = a / b;
        r = a % b;
      end
      lat = sp ? 1 : 66;
    end
  endfunction

  task automatic run_op(
    input logic [63:0] a,
    input logic [63:0] b,
    input bit          s,
    input bit          w,
    input int          hold,
    input string       nm
  );
    logic [63:0] eq, er;
    int elat, lat;
    bit seen, busy_bad;
    model(a, b, s, w, eq, er, elat);
    out_ready = (hold == 0);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    is_word   = w;
    in_valid  = 1;
    tick();
    in_valid  = 0;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
    is_signed = ~s;
    is_word   = ~w;
    lat = 1;
    seen = 0;
    busy_bad = 0;
    while (lat < 200) begin
      if (in_ready) busy_bad = 1;
      if (out_valid) begin
        seen = 1;
        break;
      end
      tick();
      lat++;
    end
    total++;
    if (!seen || lat != elat) begin
      bad++;
      $display("FAIL %s latency: got %0d seen=%0b want %0d",
               nm, lat, seen, elat);
    end
    total++;
    if (quotient !== eq) begin
      bad++;
      $display("FAIL %s quotient: got %h want %h",
               nm, quotient, eq);
    end
    total++;
    if (remainder !== er) begin
      bad++;
      $display("FAIL %s remainder: got %h want %h",
               nm, remainder, er);
    end
    total++;
    if (busy_bad) begin
      bad++;
      $display("FAIL %s busy_ready: got in_ready=1 want 0", nm);
    end
    for (int i = 1; i < hold; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          quotient !== eq || remainder !== er) begin
        bad++;
        $display("FAIL %s hold: got v=%0b rdy=%0b q=%h r=%h want v=1 rdy=0 q=%h r=%h",
                 nm, out_valid, in_ready, quotient, remainder,
                 eq, er);
      end
    end
    out_ready = 1;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s drain: got v=%0b rdy=%0b want v=0 rdy=1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) tick();
    reset_n = 1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        quotient !== 64'd0 || remainder !== 64'd0) begin
      bad++;
      $display("FAIL reset: got rdy=%0b v=%0b q=%h r=%h want 1 0 0 0",
               in_ready, out_valid, quotient, remainder);
    end
  endtask

  task automatic test_directed();
    run_op(64'd100, 64'd7, 0, 0, 0, "divu_100_7");
    run_op(-64'sd7, 64'd2, 1, 0, 0, "div_m7_2");
    run_op(64'd7, -64'sd2, 1, 0, 0, "div_7_m2");
    run_op(64'h1234, 64'd0, 0, 0, 0, "divu_by0");
    run_op(64'h8000_0000_0000_0000, '1, 1, 0, 0, "div_ovf");
    run_op(64'h1_0000_0010, 64'd2, 0, 1, 0, "divuw");
    run_op(64'h8000_0000, '1, 1, 1, 0, "divw_ovf");
    run_op(-64'sd9, 64'd4, 1, 1, 0, "remw_m9_4");
    run_op(64'h8000_0000_0000_0000, 64'd3, 1, 0, 0, "div_min_3");
    run_op(64'hFFFF_FFFF_8000_0000, 64'd2, 1, 1, 0, "divw_min_2");
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    bit s, w;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: b = '1;
        2: b = 64'($urandom_range(1, 20));
        3: b = -64'($urandom_range(1, 20));
        4: b = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: b = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 4))
        0: a = 64'h8000_0000_0000_0000;
        1: a = {$urandom, 32'h8000_0000};
        2: a = a >> $urandom_range(0, 63);
        default: ;
      endcase
      s = $urandom_range(0, 1);
      w = $urandom_range(0, 1);
      run_op(a, b, s, w, 0, "random");
    end
  endtask

  task automatic test_flush();
    bit saw = 0;
    out_ready = 1;
    dividend = 64'd1000;
    divisor = 64'd3;
    is_signed = 0;
    is_word = 0;
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (9) begin
      tick();
      if (out_valid) saw = 1;
    end
    flush = 1;
    tick();
    flush = 0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || saw) begin
      bad++;
      $display("FAIL flush_calc: got rdy=%0b v=%0b saw=%0b want 1 0 0",
               in_ready, out_valid, saw);
    end
    run_op(64'd50, 64'd5, 0, 0, 0, "after_flush");
  endtask

  task automatic test_flush_idle();
    dividend = 64'd5;
    divisor = 64'd0;
    is_signed = 0;
    is_word = 0;
    in_valid = 1;
    flush = 1;
    tick();
    in_valid = 0;
    flush = 0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle: got rdy=%0b v=%0b want 1 0",
               in_ready, out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_late: got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    run_op(64'd12345, 64'd17, 0, 0, 5, "backpressure");
    run_op(-64'sd1000, 64'd7, 1, 1, 3, "bp_word");
    run_op(64'd9, 64'd0, 1, 1, 4, "bp_by0");
  endtask

  task automatic test_reset_mid();
    run_op(64'd77, 64'd0, 0, 0, 0, "pre_reset");
    dividend = 64'hDEAD_BEEF;
    divisor = 64'd3;
    is_signed = 0;
    is_word = 0;
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (5) tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        quotient !== 64'd0 || remainder !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid: got rdy=%0b v=%0b q=%h r=%h want 1 0 0 0",
               in_ready, out_valid, quotient, remainder);
    end
    run_op(64'd81, 64'd9, 0, 0, 0, "post_reset");
  endtask

  initial begin
    reset_n = 0;
    in_valid = 0;
    dividend = 0;
    divisor = 0;
    is_signed = 0;
    is_word = 0;
    flush = 0;
    out_ready = 1;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
